// File: rtl/module_dato.sv
// -----------------------------------------------------------------------------
// module_dato
// Registered key-code decoder for the 4x4 matrix-keypad path of the
// multiplier. A strobe from the keypad scanner captures the column/row code
// pair. The module translates the pair into a 4-bit key value and holds that
// value for the operand-capture logic.
//
// Ports
//   clk           in   1  system clock, rising-edge active
//   rst           in   1  asynchronous active-low reset (clears dato_o to 0)
//   dato_listo_i  in   1  key-valid strobe; codes are captured while high
//   dato_codc_i   in   2  encoded column/group index (0-3)
//   dato_codf_i   in   2  encoded row/position index (0-3)
//   dato_o        out  4  registered decoded key value (4'hF = non-digit)
//
// Configuration
//   DATO_HEX_KEYS_EN  undefined: every non-digit key decodes to 4'hF.
//                     defined:   non-digit keys get distinct codes 10..15.
// -----------------------------------------------------------------------------
module module_dato (
  input  logic       clk,
  input  logic       rst,
  input  logic       dato_listo_i,
  input  logic [1:0] dato_codc_i,
  input  logic [1:0] dato_codf_i,
  output logic [3:0] dato_o
);

  // Keypad layout lookup. Index is {column, row}.
  function automatic logic [3:0] decode_key(input logic [1:0] codc,
                                            input logic [1:0] codf);
    logic [3:0] key;
    case ({codc, codf})
      4'b00_00: key = 4'd1;
      4'b00_01: key = 4'd2;
      4'b00_10: key = 4'd3;
      4'b01_00: key = 4'd4;
      4'b01_01: key = 4'd5;
      4'b01_10: key = 4'd6;
      4'b10_00: key = 4'd7;
      4'b10_01: key = 4'd8;
      4'b10_10: key = 4'd9;
      4'b11_01: key = 4'd0;
`ifdef DATO_HEX_KEYS_EN
      4'b00_11: key = 4'd10;
      4'b01_11: key = 4'd11;
      4'b10_11: key = 4'd12;
      4'b11_11: key = 4'd13;
      4'b11_00: key = 4'd14;
      4'b11_10: key = 4'd15;
`endif
      // The remaining positions are non-digit keys.
      default:  key = 4'hF;
    endcase
    return key;
  endfunction

  logic [3:0] w_key;
  logic [3:0] r_dato;

  // Combinational decode of the current code pair.
  always_comb begin
    w_key = decode_key(dato_codc_i, dato_codf_i);
  end

  // Output register: loads on a valid strobe and otherwise holds its value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dato <= 4'd0;
    end else if (dato_listo_i) begin
      r_dato <= w_key;
    end else begin
      r_dato <= r_dato;
    end
  end

  assign dato_o = r_dato;

endmodule

// File: tb/tb_module_dato.sv
module tb_module_dato;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dato_listo_i = 1'b0;
  logic [1:0] dato_codc_i = 2'd0;
  logic [1:0] dato_codf_i = 2'd0;
  logic [3:0] dato_o;

  int checks = 0;
  int errors = 0;

  module_dato dut (
    .clk          (clk),
    .rst          (rst),
    .dato_listo_i (dato_listo_i),
    .dato_codc_i  (dato_codc_i),
    .dato_codf_i  (dato_codf_i),
    .dato_o       (dato_o)
  );

  always #5 clk = ~clk;

  // Reference key map. Digits follow the phone-like layout col*3+row+1.
  // Column 3 row 1 is the zero key.
  function automatic logic [3:0] key_model(input int c, input int r);
    if (c < 3 && r < 3) return 4'(c * 3 + r + 1);
    if (c == 3 && r == 1) return 4'd0;
`ifdef DATO_HEX_KEYS_EN
    if (r == 3) return 4'(10 + c);
    if (c == 3 && r == 0) return 4'd14;
    return 4'd15;
`else
    return 4'd15;
`endif
  endfunction

  // Model of the output register.
  logic [3:0] m_exp = 4'd0;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_exp <= 4'd0;
    else if (dato_listo_i) m_exp <= key_model(int'(dato_codc_i), int'(dato_codf_i));
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_cmp", dato_o, m_exp);
  end

  task automatic drive(input int c, input int r, input logic l);
    @(negedge clk);
    #2;
    dato_codc_i  = 2'(c);
    dato_codf_i  = 2'(r);
    dato_listo_i = l;
  endtask

  task automatic after_edge(input string name, input logic [3:0] exp);
    @(posedge clk);
    #1;
    check(name, dato_o, exp);
  endtask

  int sw_c [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
  int sw_r [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 1};
  logic [3:0] sw_e [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
  int nd_c [6] = '{0, 1, 2, 3, 3, 3};
  int nd_r [6] = '{3, 3, 3, 0, 2, 3};
`ifdef DATO_HEX_KEYS_EN
  logic [3:0] nd_e [6] = '{4'd10, 4'd11, 4'd12, 4'd14, 4'd15, 4'd13};
  localparam logic [3:0] K33 = 4'd13;
`else
  logic [3:0] nd_e [6] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
  localparam logic [3:0] K33 = 4'd15;
`endif

  initial begin
    // Reset is asserted with a pending strobe and no clock edge yet.
    dato_listo_i = 1'b1;
    dato_codc_i  = 2'd2;
    dato_codf_i  = 2'd1;
    #1 rst = 1'b0;
    #1 check("reset_async", dato_o, 4'd0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold_listo", dato_o, 4'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    after_edge("reset_release_8", 4'd8);

    // Digit sweep
    for (int i = 0; i < 10; i++) begin
      drive(sw_c[i], sw_r[i], 1'b1);
      after_edge("digit", sw_e[i]);
    end

    // Non-digit keys
    for (int i = 0; i < 6; i++) begin
      drive(nd_c[i], nd_r[i], 1'b1);
      after_edge("nondigit", nd_e[i]);
    end

    // Hold with strobe low
    drive(3, 3, 1'b1);
    after_edge("hold_capture", K33);
    drive(1, 1, 1'b0);
    for (int i = 0; i < 4; i++) after_edge("hold", K33);
    drive(1, 1, 1'b1);
    after_edge("hold_resume_5", 4'd5);

    // Async reset mid-stream
    drive(2, 1, 1'b1);
    after_edge("mid_load_8", 4'd8);
    #2 rst = 1'b0;
    #1 check("mid_reset_async", dato_o, 4'd0);
    @(posedge clk);
    #1 check("mid_reset_hold", dato_o, 4'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    after_edge("mid_reset_resume_8", 4'd8);

    // Code change and strobe fall at the same edge: old value held
    drive(2, 2, 1'b1);
    after_edge("simul_load_9", 4'd9);
    drive(0, 0, 1'b0);
    after_edge("simul_hold_9", 4'd9);
    after_edge("simul_hold_9b", 4'd9);

`ifdef DATO_HEX_KEYS_EN
    drive(3, 1, 1'b1);
    after_edge("hex_digit_0", 4'd0);
    drive(2, 2, 1'b1);
    after_edge("hex_digit_9", 4'd9);
`endif

    // Continuous strobe follows changes with one-cycle latency
    drive(0, 2, 1'b1);
    after_edge("follow_3", 4'd3);
    drive(1, 0, 1'b1);
    after_edge("follow_4", 4'd4);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_dato.md
# module_dato

Registered key-code decoder for the 4x4 matrix-keypad path of the multiplier. It takes the 2-bit column code and the 2-bit row code from the keypad scanner/encoder. When the scanner flags a valid key press, it converts the pair into a 4-bit key value. The value is held on `dato_o` for the downstream operand-capture logic.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset asserted).
- `dato_listo_i` input 1: key-valid strobe from the scanner; high means the codes are stable and must be captured.
- `dato_codc_i` input 2: encoded keypad column/group index (0-3).
- `dato_codf_i` input 2: encoded keypad row/position index (0-3).
- `dato_o` output 4: registered decoded key value.

## Operation
- Combinational lookup on the pair {`dato_codc_i`, `dato_codf_i`} (default build):
  - codc=0: codf 0->1, 1->2, 2->3, 3->15.
  - codc=1: codf 0->4, 1->5, 2->6, 3->15.
  - codc=2: codf 0->7, 1->8, 2->9, 3->15.
  - codc=3: codf 0->15, 1->0, 2->15, 3->15.
- 15 (4'hF) is the "non-digit / no-number key" code; downstream logic treats it as not a digit.
- Capture:
  - On each rising `clk` edge with `dato_listo_i`=1, the output register loads the lookup result.
  - With `dato_listo_i`=0, the register holds its value indefinitely.
- No other state exists: no FSM, no debounce, no edge detection.
- While `dato_listo_i` stays high, the register reloads every cycle and follows code changes with one-cycle latency.
- All 16 input combinations are defined; X/Z are not handled specially.

## Timing
- Reset:
  - `rst`=0 clears `dato_o` to 4'd0 immediately, independent of `clk`.
  - Reset has priority over `dato_listo_i`.
- After `rst` returns high, `dato_o` stays 0 until the first rising edge with `dato_listo_i`=1.
- Latency: inputs sampled at rising edge N appear on `dato_o` just after edge N (1-cycle registered path).
- Inputs must be stable around the rising edge; `dato_listo_i` and the codes are sampled together.
- Reset mid-operation: a pending or continuous `dato_listo_i` has no effect while `rst`=0. Capture resumes on the first edge after release.
- Simultaneous code change and `dato_listo_i` fall at the same edge: nothing is captured, and the old value is held.

## Configuration
- Macro `DATO_HEX_KEYS_EN`.
- Undefined (default): all non-digit keys decode to 15, as listed above.
- Defined: non-digit keys get distinct codes. Digit keys are unchanged.
  - (0,3)->10
  - (1,3)->11
  - (2,3)->12
  - (3,3)->13
  - (3,0)->14
  - (3,2)->15

## Test plan
- Reset: hold `rst`=0 with `dato_listo_i`=1 and codes (2,1) -> `dato_o`=0 with no clock edge needed. Release `rst`; the next edge loads 8.
- Digit sweep: `dato_listo_i`=1, step through (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(2,0),(2,1),(2,2),(3,1), one per cycle -> `dato_o`=1,2,3,4,5,6,7,8,9,0, each one cycle after its code is applied.
- Non-digit keys (default build): (0,3),(1,3),(2,3),(3,0),(3,2),(3,3) -> `dato_o`=15 for each.
- Hold: capture (3,3)=15, drop `dato_listo_i` to 0, apply (1,1) for several cycles -> `dato_o` stays 15. Raise `dato_listo_i` -> 5 on the next edge.
- Async reset mid-stream: with `dato_listo_i`=1 and `dato_o`=8, pulse `rst` low between edges -> `dato_o`=0 at once. It returns to 8 on the first edge after release.
- `DATO_HEX_KEYS_EN` build: (0,3)->10, (1,3)->11, (2,3)->12, (3,3)->13, (3,0)->14, (3,2)->15. Digits are unchanged: (3,1)->0, (2,2)->9.
